// File: rtl/router_out_fifo.sv
// router_out_fifo: per-destination output buffer of the 1x3 router.
// Stores {header_tag, byte} words and registers popped bytes onto data_out.
// The remaining length of the packet being read is loaded from each header
// byte; pkt_done marks its last (parity) byte. A destination that leaves
// valid data unread for TIMEOUT cycles causes a soft-reset flush.
// Optional feature macro: ROUTER_FIFO_OVF_FLAG_EN enables the sticky ovf
// flag. When it is undefined, ovf is tied low.
module router_out_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             write_enb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lfd,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  output logic             full,
  output logic             empty,
  output logic             soft_rst,
  output logic             pkt_done,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = WIDTH - 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             pkt_done_q, pkt_done_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             tmo_run;
  logic             tmo_fire;
  logic [WIDTH:0]   rd_word;

  // Both flags come from the registered pointers. The MSB is the wrap bit.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign vld_out = ~empty;

  // The timeout fires in the same cycle as the last idle cycle it counts.
  // A write in that cycle is lost with the flush.
  assign tmo_run  = vld_out && !read_enb;
  assign tmo_fire = tmo_run && (tcnt_q == TW'(TIMEOUT - 1));
  assign soft_rst = tmo_fire;

  // A write at full and a read at empty are ignored.
  // This also covers the cases where read and write occur together.
  assign wr_acc  = write_enb && !full && !tmo_fire;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  assign data_out = data_out_q;
  assign pkt_done = pkt_done_q;

  // Next-state logic for pointers, output byte, packet length and timeout
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    rem_d      = rem_q;
    pkt_done_d = 1'b0;
    tcnt_d     = '0;
    if (tmo_fire) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
      rem_d      = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        data_out_d = rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          // Header: payload length plus the parity byte. A header that
          // arrives mid-packet restarts the count.
          rem_d = RW'({1'b0, rd_word[WIDTH-1:2]}) + RW'(1);
        end else if (rem_q != '0) begin
          rem_d      = rem_q - RW'(1);
          pkt_done_d = (rem_q == RW'(1));
        end
      end else if (pkt_done_q) begin
        data_out_d = '0;
      end
      if (tmo_run) begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  // Control registers. Async reset drops any packet being read.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      rem_q      <= '0;
      tcnt_q     <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      rem_q      <= rem_d;
      tcnt_q     <= tcnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Storage array. It has no reset because the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd, data_in};
    end
  end

`ifdef ROUTER_FIFO_OVF_FLAG_EN
  logic ovf_q;

  // Sticky flag for a write dropped at full. It is cleared by reset or by a timeout flush.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (tmo_fire) begin
      ovf_q <= 1'b0;
    end else if (write_enb && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_fifo.sv
// Self-checking bench for router_out_fifo with a queue-based reference model.
module tb_router_out_fifo;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;
`ifdef ROUTER_FIFO_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             write_enb = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             lfd = 1'b0;
  logic             read_enb = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             vld_out, full, empty, soft_rst, pkt_done, ovf;

  int errors = 0;
  int checks = 0;

  router_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .rst(rst), .write_enb(write_enb), .data_in(data_in),
    .lfd(lfd), .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
    .full(full), .empty(empty), .soft_rst(soft_rst), .pkt_done(pkt_done),
    .ovf(ovf)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [WIDTH:0]   mq[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_pd = 1'b0;
  bit               m_ovf = 1'b0;
  int               m_rem = 0;
  int               m_tcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds the stored words, and the counters follow the packet rules.
  always @(posedge clock or posedge rst) begin
    int n;
    bit fire, rd, wr, npd;
    logic [WIDTH:0] w;
    if (rst) begin
      mq.delete();
      m_dout = '0; m_pd = 0; m_rem = 0; m_tcnt = 0; m_ovf = 0;
    end else begin
      n = mq.size();
      fire = (n != 0) && !read_enb && (m_tcnt == TIMEOUT - 1);
      if (fire) begin
        mq.delete();
        m_dout = '0; m_pd = 0; m_rem = 0; m_tcnt = 0; m_ovf = 0;
      end else begin
        if (OVF_EN && write_enb && n == DEPTH) m_ovf = 1;
        rd = read_enb && (n != 0);
        wr = write_enb && (n != DEPTH);
        npd = 0;
        if (rd) begin
          w = mq.pop_front();
          m_dout = w[WIDTH-1:0];
          if (w[WIDTH]) m_rem = int'(w[WIDTH-1:2]) + 1;
          else if (m_rem != 0) begin
            m_rem = m_rem - 1;
            npd = (m_rem == 0);
          end
        end else if (m_pd) begin
          m_dout = '0;
        end
        m_pd = npd;
        if (wr) mq.push_back({lfd, data_in});
        m_tcnt = ((n != 0) && !read_enb) ? m_tcnt + 1 : 0;
      end
    end
  end

  // Per-cycle comparison against the model. Inputs for the next edge are already applied at this point.
  always begin
    @(negedge clock);
    #2;
    if (!rst) begin
      check("data_out", 32'(data_out), 32'(m_dout));
      check("vld_out", 32'(vld_out), 32'(mq.size() != 0));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("pkt_done", 32'(pkt_done), 32'(m_pd));
      check("soft_rst", 32'(soft_rst),
            32'((mq.size() != 0) && !read_enb && (m_tcnt == TIMEOUT - 1)));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic tick(input bit we, input logic [WIDTH-1:0] d, input bit l, input bit re);
    @(negedge clock);
    #1;
    write_enb = we; data_in = d; lfd = l; read_enb = re;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    tick(0, '0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] pkt [5];
    int fire_at;
    int seen;
    int n;
    bit we, re;

    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_vld", 32'(vld_out), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_soft_rst", 32'(soft_rst), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clock); #1; rst = 1'b0;

    // Async reset while a packet is partly stored and partly read
    tick(1, 8'h14, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, 8'(8'h60 + i), 0, 0);
    tick(0, '0, 0, 1);
    check("pre_rst_data_out", 32'(data_out), 32'h14);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_vld", 32'(vld_out), 32'd0);
    check("async_rst_data_out", 32'(data_out), 32'd0);
    read_enb = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1; rst = 1'b0;

    // One packet: header 0x0C (3 payload bytes) plus parity
    for (int i = 0; i < 5; i++) tick(1, pkt[i], (i == 0), 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, '0, 0, 1);
      check("pkt_byte", 32'(data_out), 32'(pkt[i]));
      check("pkt_done_pos", 32'(pkt_done), 32'(i == 4));
    end
    idle();
    check("pkt_after_data_out", 32'(data_out), 32'd0);
    check("pkt_after_done", 32'(pkt_done), 32'd0);

    // Fill to full, push a dropped write, then drain
    for (int i = 0; i < DEPTH; i++) tick(1, 8'(i * 7 + 3), 0, 0);
    check("fill_full", 32'(full), 32'd1);
    tick(1, 8'hAA, 0, 0);
    check("drop_full", 32'(full), 32'd1);
    check("drop_ovf", 32'(ovf), 32'(OVF_EN));
    for (int i = 0; i < DEPTH; i++) begin
      tick(0, '0, 0, 1);
      check("drain_byte", 32'(data_out), 32'(8'(i * 7 + 3)));
    end
    idle();
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous read and write while full, then while empty
    for (int i = 0; i < DEPTH; i++) tick(1, 8'(8'h50 + i), 0, 0);
    tick(1, 8'hEE, 0, 1);
    check("rw_full_data", 32'(data_out), 32'h50);
    check("rw_full_flag", 32'(full), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      tick(0, '0, 0, 1);
      check("rw_drain", 32'(data_out), 32'(8'(8'h50 + i)));
    end
    check("rw_empty", 32'(empty), 32'd1);
    tick(1, 8'h77, 0, 1);
    check("rw_empty_data", 32'(data_out), 32'h5F);
    check("rw_empty_vld", 32'(vld_out), 32'd1);
    tick(0, '0, 0, 1);
    check("rw_empty_pop", 32'(data_out), 32'h77);
    idle();

    // Timeout: 3 bytes stored and never read
    tick(1, 8'h01, 0, 0);
    fire_at = 0;
    for (int k = 1; k <= 29; k++) begin
      if (k <= 2) tick(1, 8'(k + 1), 0, 0);
      else idle();
      if (soft_rst && fire_at == 0) fire_at = k + 1;
    end
    check("tmo_fire_cycle", 32'(fire_at), 32'd30);
    idle();
    check("tmo_flush_empty", 32'(empty), 32'd1);
    check("tmo_pulse_end", 32'(soft_rst), 32'd0);

    // Timeout restart: one read at cycle 29 prevents the flush
    tick(1, 8'h09, 0, 0);
    seen = 0;
    for (int k = 1; k <= 57; k++) begin
      if (k <= 2) tick(1, 8'(k + 9), 0, 0);
      else if (k == 29) tick(0, '0, 0, 1);
      else idle();
      if (soft_rst) seen++;
    end
    check("tmo_restart_none", 32'(seen), 32'd0);
    idle();
    check("tmo_restart_fire", 32'(soft_rst), 32'd1);
    idle();
    check("tmo_restart_empty", 32'(empty), 32'd1);

    // Back-to-back push/pop at steady occupancy, which wraps the pointers
    for (int i = 0; i < 8; i++) tick(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) tick(1, 8'($urandom), 0, 1);
    for (int i = 0; i < 200; i++) begin
      n = mq.size();
      if (n <= 1) begin we = 1; re = 0; end
      else if (n >= 15) begin we = 0; re = 1; end
      else begin we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1)); end
      tick(we, 8'($urandom), ($urandom_range(0, 7) == 0), re);
    end

    // Unconstrained traffic, with reads that are sometimes rare enough to reach full and hit timeouts
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0));
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
